edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter_if.sv | 22 ++
 rtl/edge_event_arbiter.sv | 115 +++++++++++
 tb/tb_edge_event_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Event handshake between the edge arbiter and its consumer.
// The arbiter drives the master side; the consumer answers with ev_ready.
interface edge_event_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
);
   logic           ev_valid;
   logic [IDW-1:0] ev_id;
   logic           ev_ready;

   modport master (
      output ev_valid,
      output ev_id,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_id,
      output ev_ready
   );
endinterface

// File: rtl/edge_event_arbiter.sv
// Synchronizes N asynchronous levels, latches their rising edges as pending
// events and offers them one at a time through a round-robin valid/ready port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no offer outstanding; pick the next pending channel if any
//   OFFER | ev_valid high, ev_id held until the consumer raises ev_ready
module edge_event_arbiter #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         level,
   edge_event_arbiter_if.master ev,
   output logic [N-1:0]         pend,
   output logic [N-1:0]         ovf,
   input  logic [N-1:0]         ovf_clr
);
   localparam int IDW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   logic [N-1:0]   sync_q [SYNC_STAGES];
   logic [N-1:0]   delay_q;
   logic [N-1:0]   sync_out;
   logic [N-1:0]   tick;
   logic [N-1:0]   acc;
   logic           ev_valid_w;

   state_t         state_q, state_d;
   logic [IDW-1:0] ev_id_q, ev_id_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] pick;
   logic           found;
   int             cand_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         delay_q <= '0;
      end else begin
         sync_q[0] <= level;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         delay_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign tick       = sync_out & ~delay_q;
   assign ev_valid_w = (state_q == OFFER);
   assign acc        = (ev_valid_w && ev.ev_ready) ? (N'(1) << ev_id_q) : '0;

   // A tick coinciding with an accept re-arms the flag instead of overflowing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend <= '0;
         ovf  <= '0;
      end else begin
         pend <= (pend & ~acc) | tick;
         ovf  <= (ovf & ~ovf_clr) | (tick & pend & ~acc);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ev_id_q <= '0;
         last_q  <= IDW'(N - 1);
      end else begin
         state_q <= state_d;
         ev_id_q <= ev_id_d;
         last_q  <= last_d;
      end
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      state_d = state_q;
      ev_id_d = ev_id_q;
      last_d  = last_q;
      found   = 1'b0;
      pick    = '0;
      cand_i  = 0;
      for (int k = 1; k <= N; k++) begin
         cand_i = int'(last_q) + k;
         if (cand_i >= N) cand_i = cand_i - N;
         if (!found && pend[IDW'(cand_i)]) begin
            found = 1'b1;
            pick  = IDW'(cand_i);
         end
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               ev_id_d = pick;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (ev.ev_ready) begin
               last_d  = ev_id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ev.ev_valid = ev_valid_w;
   assign ev.ev_id    = ev_id_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic, all
// checked by a scoreboard fed from a delay-line/round-robin reference model.
module tb_edge_event_arbiter;
   localparam int N   = 4;
   localparam int S   = 2;
   localparam int IDW = $clog2(N);

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] level;
   logic [N-1:0] ovf_clr;
   logic         ready;
   logic [N-1:0] pend;
   logic [N-1:0] ovf;

   edge_event_arbiter_if #(.N(N)) bus();
   assign bus.ev_ready = ready;

   edge_event_arbiter #(.N(N), .SYNC_STAGES(S)) dut (
      .clk     (clk),
      .reset   (reset),
      .level   (level),
      .ev      (bus),
      .pend    (pend),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_q[$];
   int acc_log[$];
   int acc_cyc[$];

   logic [N-1:0] hist [S+1];
   logic [N-1:0] m_pend, m_ovf;
   logic         m_off;
   int           m_id, m_last;

   int first, nvalid, n0, n1;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: a level sampled at edge u becomes a rise at edge u+S.
   always @(posedge clk or posedge reset) begin : model
      logic [N-1:0] r, accv;
      int           pick;
      if (reset) begin
         for (int k = 0; k <= S; k++) hist[k] <= '0;
         m_pend <= '0;
         m_ovf  <= '0;
         m_off  <= 1'b0;
         m_id   <= 0;
         m_last <= N - 1;
         exp_q.delete();
      end else begin
         r    = hist[S-1] & ~hist[S];
         accv = (m_off && ready) ? (N'(1) << m_id) : '0;
         m_pend <= (m_pend & ~accv) | r;
         m_ovf  <= (m_ovf & ~ovf_clr) | (r & m_pend & ~accv);
         hist[0] <= level;
         for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
         pick = -1;
         if (!m_off && m_pend != '0) begin
            for (int k = 1; k <= N; k++)
               if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
            m_off <= 1'b1;
            m_id  <= pick;
            exp_q.push_back(pick);
         end else if (m_off && ready) begin
            m_off  <= 1'b0;
            m_last <= m_id;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      chk("ev_valid", int'(bus.ev_valid), int'(m_off));
      chk("pend", int'(pend), int'(m_pend));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (bus.ev_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            chk("ev_id", int'(bus.ev_id), exp_q[0]);
            if (ready) begin
               acc_log.push_back(int'(bus.ev_id));
               acc_cyc.push_back(cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      level   = '0;
      ready   = 1'b0;
      ovf_clr = '0;
      reset   = 1'b1;
      step(2);
      reset   = 1'b0;
      step(1);
      acc_log.delete();
      acc_cyc.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b0;
      level   = '0;
      ready   = 1'b0;
      ovf_clr = '0;
      #2 reset = 1'b1;
      #1;
      chk("rst_ev_valid", int'(bus.ev_valid), 0);
      chk("rst_ev_id", int'(bus.ev_id), 0);
      chk("rst_pend", int'(pend), 0);
      chk("rst_ovf", int'(ovf), 0);
      step(2);
      reset = 1'b0;
      step(1);

      // single rise to a ready consumer: offer at edge S+2, one cycle only
      do_reset();
      ready    = 1'b1;
      level[2] = 1'b1;
      first    = 0;
      nvalid   = 0;
      for (int e = 1; e <= 12; e++) begin
         step(1);
         if (bus.ev_valid) begin
            nvalid++;
            if (first == 0) begin
               first = e;
               chk("lat_id", int'(bus.ev_id), 2);
            end
         end
      end
      chk("lat_edge", first, S + 2);
      chk("lat_single", nvalid, 1);
      chk("lat_pend_clear", int'(pend), 0);

      // all channels rise together
      do_reset();
      ready = 1'b1;
      level = '1;
      step(20);
      chk("all_count", acc_log.size(), 4);
      for (int k = 0; k < acc_log.size(); k++) chk("all_order", acc_log[k], k);
      for (int k = 1; k < acc_cyc.size(); k++) chk("all_gap", acc_cyc[k] - acc_cyc[k-1], 2);

      // back-pressure
      do_reset();
      level[1] = 1'b1;
      step(5);
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid", int'(bus.ev_valid), 1);
         chk("bp_id", int'(bus.ev_id), 1);
         step(1);
      end
      ready = 1'b1;
      step(1);
      chk("bp_accepted", acc_log.size(), 1);
      if (acc_log.size() > 0) chk("bp_acc_id", acc_log[0], 1);
      chk("bp_valid_drop", int'(bus.ev_valid), 0);

      // overflow: second rise while the first is still pending
      do_reset();
      level[0] = 1'b1;
      step(5);
      level[0] = 1'b0;
      step(5);
      level[0] = 1'b1;
      step(5);
      level[0] = 1'b0;
      step(3);
      chk("ovf0_set", int'(ovf[0]), 1);
      ready = 1'b1;
      step(6);
      ready = 1'b0;
      chk("ovf_one_event", acc_log.size(), 1);
      chk("ovf_sticky", int'(ovf[0]), 1);
      ovf_clr[0] = 1'b1;
      step(1);
      ovf_clr = '0;
      chk("ovf0_cleared", int'(ovf[0]), 0);

      // fairness between two continuously pulsing channels
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 48; c++) begin
         level[1:0] = ((c % 4) < 2) ? 2'b11 : 2'b00;
         step(1);
      end
      level = '0;
      step(10);
      n0 = 0;
      n1 = 0;
      foreach (acc_log[k]) if (acc_log[k] == 0) n0++; else n1++;
      chk("rr_enough", int'(acc_log.size() >= 10), 1);
      chk("rr_balance", int'((n0 - n1) <= 1 && (n1 - n0) <= 1), 1);
      for (int k = 1; k < acc_log.size(); k++)
         chk("rr_alternate", int'(acc_log[k] != acc_log[k-1]), 1);

      // a level already high at reset release yields exactly one event
      level   = 4'b0010;
      ready   = 1'b1;
      reset   = 1'b1;
      step(2);
      reset   = 1'b0;
      acc_log.delete();
      step(12);
      chk("held_level_events", acc_log.size(), 1);

      // asynchronous reset during an offer
      do_reset();
      level[3] = 1'b1;
      step(5);
      level[3] = 1'b0;
      step(5);
      level[3] = 1'b1;
      step(5);
      chk("mid_pre_valid", int'(bus.ev_valid), 1);
      chk("mid_pre_ovf", int'(ovf[3]), 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_valid", int'(bus.ev_valid), 0);
      chk("mid_pend", int'(pend), 0);
      chk("mid_ovf", int'(ovf), 0);
      level = '0;
      ready = 1'b1;
      step(2);
      reset = 1'b0;
      acc_log.delete();
      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (bus.ev_valid) nvalid++;
      end
      chk("mid_no_valid", nvalid, 0);
      chk("mid_no_accept", acc_log.size(), 0);

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) level[i] = ~level[i];
         ready   = ($urandom_range(0, 2) != 0);
         ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         step(1);
      end
      level   = '0;
      ovf_clr = '0;
      ready   = 1'b1;
      step(20);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_idle", int'(bus.ev_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
